// File: rtl/stream_split2.sv
// One-to-two stream splitter: CONFIG==0 broadcasts every word to both lanes, otherwise words alternate out0/out1.
// Optional per-lane transfer counters are enabled with the STREAM_SPLIT2_COUNT_EN macro.
module stream_split2 #(
    parameter int CONFIG = 0,
    parameter int WIDTH  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef STREAM_SPLIT2_COUNT_EN
    ,
    output logic [15:0]      out0_count,
    output logic [15:0]      out1_count
`endif
);

    logic [1:0]            w_out_ready;
    logic [1:0]            w_can_load;
    logic [1:0]            w_load;
    logic [1:0]            w_valid;
    logic [1:0][WIDTH-1:0] w_data;
    logic                  w_in_xfer;

    assign w_out_ready = {out1_ready, out0_ready};
    // A lane slot can take a word if it is empty or is being drained this cycle.
    assign w_can_load  = ~w_valid | w_out_ready;
    assign w_in_xfer   = in_valid & in_ready;

    generate
        if (CONFIG == 0) begin : g_bcast
            assign in_ready = w_can_load[0] & w_can_load[1];
            assign w_load   = {w_in_xfer, w_in_xfer};
        end else begin : g_rr
            logic r_sel;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_sel <= 1'b0;
                end else if (w_in_xfer) begin
                    r_sel <= ~r_sel;
                end
            end

            assign in_ready = r_sel ? w_can_load[1] : w_can_load[0];
            assign w_load   = {w_in_xfer & r_sel, w_in_xfer & ~r_sel};
        end
    endgenerate

`ifdef STREAM_SPLIT2_COUNT_EN
    logic [1:0][15:0] w_count;
`endif

    generate
        for (genvar k = 0; k < 2; k++) begin : g_lane
            logic             r_valid;
            logic [WIDTH-1:0] r_data;

            // A load wins over a drain so a same-cycle drain and reload leaves no bubble.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_load[k]) begin
                    r_valid <= 1'b1;
                    r_data  <= in_data;
                end else if (r_valid && w_out_ready[k]) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_valid[k] = r_valid;
            assign w_data[k]  = r_data;

`ifdef STREAM_SPLIT2_COUNT_EN
            logic [15:0] r_count;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_count <= 16'h0000;
                end else if (r_valid && w_out_ready[k]) begin
                    r_count <= r_count + 16'h0001;
                end
            end

            assign w_count[k] = r_count;
`endif
        end
    endgenerate

    assign out0_valid = w_valid[0];
    assign out0_data  = w_data[0];
    assign out1_valid = w_valid[1];
    assign out1_data  = w_data[1];

`ifdef STREAM_SPLIT2_COUNT_EN
    assign out0_count = w_count[0];
    assign out1_count = w_count[1];
`endif

endmodule

// File: tb/tb_stream_split2.sv
// Bench for stream_split2: a broadcast instance (index 0) and a round-robin instance (index 1)
// driven by directed scenarios and a randomized run checked against a queue-based lane model.
module tb_stream_split2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iv  [2];
    logic [3:0] id  [2];
    logic       ir  [2];
    logic [3:0] o0d [2];
    logic [3:0] o1d [2];
    logic       o0v [2];
    logic       o1v [2];
    logic       r0  [2];
    logic       r1  [2];
`ifdef STREAM_SPLIT2_COUNT_EN
    logic [15:0] c0 [2];
    logic [15:0] c1 [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per lane (index d*2+k), routing pointer and transfer counts.
    logic [3:0]  mq   [4][$];
    logic        msel [2];
    logic [15:0] mcnt [4];

    always #5 clock = ~clock;

    stream_split2 #(.CONFIG(0), .WIDTH(4)) u_bcast (
        .clock(clock), .reset(reset),
        .in_data(id[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .out0_data(o0d[0]), .out0_valid(o0v[0]), .out0_ready(r0[0]),
        .out1_data(o1d[0]), .out1_valid(o1v[0]), .out1_ready(r1[0])
`ifdef STREAM_SPLIT2_COUNT_EN
        , .out0_count(c0[0]), .out1_count(c1[0])
`endif
    );

    stream_split2 #(.CONFIG(1), .WIDTH(4)) u_rr (
        .clock(clock), .reset(reset),
        .in_data(id[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .out0_data(o0d[1]), .out0_valid(o0v[1]), .out0_ready(r0[1]),
        .out1_data(o1d[1]), .out1_valid(o1v[1]), .out1_ready(r1[1])
`ifdef STREAM_SPLIT2_COUNT_EN
        , .out0_count(c0[1]), .out1_count(c1[1])
`endif
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; id[d] = 4'h0; r0[d] = 1'b1; r1[d] = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_all();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (o0v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_o0v[%0d]: got %b want 0", d, o0v[d]); end
            n_tests++; if (o1v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_o1v[%0d]: got %b want 0", d, o1v[d]); end
            n_tests++; if (o0d[d] !== 4'h0) begin n_fail++; $display("FAIL reset_o0d[%0d]: got %h want 0", d, o0d[d]); end
            n_tests++; if (o1d[d] !== 4'h0) begin n_fail++; $display("FAIL reset_o1d[%0d]: got %h want 0", d, o1d[d]); end
            n_tests++; if (ir[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, ir[d]); end
`ifdef STREAM_SPLIT2_COUNT_EN
            n_tests++; if (c0[d] !== 16'h0) begin n_fail++; $display("FAIL reset_c0[%0d]: got %0d want 0", d, c0[d]); end
            n_tests++; if (c1[d] !== 16'h0) begin n_fail++; $display("FAIL reset_c1[%0d]: got %0d want 0", d, c1[d]); end
`endif
        end
    endtask

    task automatic test_broadcast_b2b();
        logic [3:0] w [3];
        w = '{4'h3, 4'hA, 4'h5};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; id[0] = w[i];
            #1;
            n_tests++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, ir[0]); end
            tick();
            n_tests++; if (o0v[0] !== 1'b1 || o0d[0] !== w[i]) begin n_fail++; $display("FAIL b2b_out0[%0d]: got v=%b d=%h want v=1 d=%h", i, o0v[0], o0d[0], w[i]); end
            n_tests++; if (o1v[0] !== 1'b1 || o1d[0] !== w[i]) begin n_fail++; $display("FAIL b2b_out1[%0d]: got v=%b d=%h want v=1 d=%h", i, o1v[0], o1d[0], w[i]); end
        end
        iv[0] = 1'b0;
        tick();
        n_tests++; if (o0v[0] !== 1'b0 || o1v[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got v0=%b v1=%b want 0 0", o0v[0], o1v[0]); end
    endtask

    task automatic test_broadcast_stall();
        do_reset();
        r1[0] = 1'b0;
        iv[0] = 1'b1; id[0] = 4'h7;
        #1;
        n_tests++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bstall_ready_first: got %b want 1", ir[0]); end
        tick();
        n_tests++; if (o0v[0] !== 1'b1 || o0d[0] !== 4'h7 || o1v[0] !== 1'b1 || o1d[0] !== 4'h7) begin
            n_fail++; $display("FAIL bstall_load7: got %b/%h %b/%h want 1/7 1/7", o0v[0], o0d[0], o1v[0], o1d[0]); end
        id[0] = 4'h9;
        #1;
        n_tests++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL bstall_ready_blocked: got %b want 0", ir[0]); end
        tick();
        n_tests++; if (o0v[0] !== 1'b0 || o1v[0] !== 1'b1 || o1d[0] !== 4'h7) begin
            n_fail++; $display("FAIL bstall_hold: got v0=%b v1=%b d1=%h want 0 1 7", o0v[0], o1v[0], o1d[0]); end
        n_tests++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL bstall_ready_still: got %b want 0", ir[0]); end
        r1[0] = 1'b1;
        #1;
        n_tests++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bstall_ready_release: got %b want 1", ir[0]); end
        tick();
        n_tests++; if (o0v[0] !== 1'b1 || o0d[0] !== 4'h9 || o1v[0] !== 1'b1 || o1d[0] !== 4'h9) begin
            n_fail++; $display("FAIL bstall_load9: got %b/%h %b/%h want 1/9 1/9", o0v[0], o0d[0], o1v[0], o1d[0]); end
        iv[0] = 1'b0;
    endtask

    task automatic test_rr_alternate();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            iv[1] = 1'b1; id[1] = 4'(i + 1);
            #1;
            n_tests++; if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL rr_in_ready[%0d]: got %b want 1", i, ir[1]); end
            tick();
            if (i % 2 == 0) begin
                n_tests++; if (o0v[1] !== 1'b1 || o0d[1] !== 4'(i + 1) || o1v[1] !== 1'b0) begin
                    n_fail++; $display("FAIL rr_word%0d_out0: got v0=%b d0=%h v1=%b want 1 %h 0", i, o0v[1], o0d[1], o1v[1], 4'(i + 1)); end
            end else begin
                n_tests++; if (o1v[1] !== 1'b1 || o1d[1] !== 4'(i + 1) || o0v[1] !== 1'b0) begin
                    n_fail++; $display("FAIL rr_word%0d_out1: got v1=%b d1=%h v0=%b want 1 %h 0", i, o1v[1], o1d[1], o0v[1], 4'(i + 1)); end
            end
        end
        iv[1] = 1'b0;
    endtask

    task automatic test_rr_stall();
        do_reset();
        r1[1] = 1'b0;
        iv[1] = 1'b1; id[1] = 4'hC;
        #1;
        n_tests++; if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL rstall_ready_C: got %b want 1", ir[1]); end
        tick();
        n_tests++; if (o0v[1] !== 1'b1 || o0d[1] !== 4'hC) begin n_fail++; $display("FAIL rstall_C_out0: got %b/%h want 1/c", o0v[1], o0d[1]); end
        id[1] = 4'hD;
        #1;
        n_tests++; if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL rstall_ready_D: got %b want 1", ir[1]); end
        tick();
        n_tests++; if (o1v[1] !== 1'b1 || o1d[1] !== 4'hD || o0v[1] !== 1'b0) begin
            n_fail++; $display("FAIL rstall_D_out1: got v1=%b d1=%h v0=%b want 1 d 0", o1v[1], o1d[1], o0v[1]); end
        id[1] = 4'hE;
        #1;
        n_tests++; if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL rstall_ready_E: got %b want 1", ir[1]); end
        tick();
        n_tests++; if (o0v[1] !== 1'b1 || o0d[1] !== 4'hE || o1v[1] !== 1'b1 || o1d[1] !== 4'hD) begin
            n_fail++; $display("FAIL rstall_E: got %b/%h %b/%h want 1/e 1/d", o0v[1], o0d[1], o1v[1], o1d[1]); end
        id[1] = 4'hF;
        #1;
        n_tests++; if (ir[1] !== 1'b0) begin n_fail++; $display("FAIL rstall_ready_F: got %b want 0", ir[1]); end
        tick();
        n_tests++; if (o1v[1] !== 1'b1 || o1d[1] !== 4'hD || o0v[1] !== 1'b0) begin
            n_fail++; $display("FAIL rstall_hold_D: got v1=%b d1=%h v0=%b want 1 d 0", o1v[1], o1d[1], o0v[1]); end
        iv[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int d = 0; d < 2; d++) begin r0[d] = 1'b0; r1[d] = 1'b0; end
        iv[0] = 1'b1; id[0] = 4'h6;
        iv[1] = 1'b1; id[1] = 4'h1;
        tick();
        iv[0] = 1'b0;
        id[1] = 4'h2;
        tick();
        iv[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (o0v[d] !== 1'b1 || o1v[d] !== 1'b1) begin n_fail++; $display("FAIL rmid_pre[%0d]: got v0=%b v1=%b want 1 1", d, o0v[d], o1v[d]); end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (o0v[d] !== 1'b0 || o1v[d] !== 1'b0 || o0d[d] !== 4'h0 || o1d[d] !== 4'h0) begin
                n_fail++; $display("FAIL rmid_clear[%0d]: got %b/%h %b/%h want 0/0 0/0", d, o0v[d], o0d[d], o1v[d], o1d[d]); end
            r0[d] = 1'b1; r1[d] = 1'b1;
        end
        iv[1] = 1'b1; id[1] = 4'h8;
        #1;
        n_tests++; if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", ir[1]); end
        tick();
        n_tests++; if (o0v[1] !== 1'b1 || o0d[1] !== 4'h8 || o1v[1] !== 1'b0) begin
            n_fail++; $display("FAIL rmid_route_out0: got v0=%b d0=%h v1=%b want 1 8 0", o0v[1], o0d[1], o1v[1]); end
        iv[1] = 1'b0;
    endtask

    task automatic test_random();
        logic cl0, cl1, exp_ir, exp_v0, exp_v1;
        do_reset();
        for (int q = 0; q < 4; q++) begin mq[q].delete(); mcnt[q] = 16'h0; end
        msel[0] = 1'b0; msel[1] = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                iv[d] = 1'($urandom_range(0, 1));
                id[d] = 4'($urandom);
                r0[d] = ($urandom_range(0, 9) < 7);
                r1[d] = ($urandom_range(0, 9) < 7);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                exp_v0 = (mq[d*2].size() != 0);
                exp_v1 = (mq[d*2+1].size() != 0);
                cl0 = !exp_v0 || r0[d];
                cl1 = !exp_v1 || r1[d];
                exp_ir = (d == 0) ? (cl0 && cl1) : (msel[d] ? cl1 : cl0);
                n_tests++; if (ir[d] !== exp_ir) begin n_fail++; $display("FAIL rnd_in_ready[%0d] cyc %0d: got %b want %b", d, cyc, ir[d], exp_ir); end
                n_tests++; if (o0v[d] !== exp_v0) begin n_fail++; $display("FAIL rnd_o0v[%0d] cyc %0d: got %b want %b", d, cyc, o0v[d], exp_v0); end
                n_tests++; if (o1v[d] !== exp_v1) begin n_fail++; $display("FAIL rnd_o1v[%0d] cyc %0d: got %b want %b", d, cyc, o1v[d], exp_v1); end
                if (exp_v0) begin
                    n_tests++; if (o0d[d] !== mq[d*2][0]) begin n_fail++; $display("FAIL rnd_o0d[%0d] cyc %0d: got %h want %h", d, cyc, o0d[d], mq[d*2][0]); end
                end
                if (exp_v1) begin
                    n_tests++; if (o1d[d] !== mq[d*2+1][0]) begin n_fail++; $display("FAIL rnd_o1d[%0d] cyc %0d: got %h want %h", d, cyc, o1d[d], mq[d*2+1][0]); end
                end
`ifdef STREAM_SPLIT2_COUNT_EN
                n_tests++; if (c0[d] !== mcnt[d*2]) begin n_fail++; $display("FAIL rnd_c0[%0d] cyc %0d: got %0d want %0d", d, cyc, c0[d], mcnt[d*2]); end
                n_tests++; if (c1[d] !== mcnt[d*2+1]) begin n_fail++; $display("FAIL rnd_c1[%0d] cyc %0d: got %0d want %0d", d, cyc, c1[d], mcnt[d*2+1]); end
`endif
                // Advance the model: deliveries leave first, then the accepted word is routed.
                if (exp_v0 && r0[d]) begin void'(mq[d*2].pop_front()); mcnt[d*2]++; end
                if (exp_v1 && r1[d]) begin void'(mq[d*2+1].pop_front()); mcnt[d*2+1]++; end
                if (iv[d] && exp_ir) begin
                    if (d == 0) begin
                        mq[0].push_back(id[d]);
                        mq[1].push_back(id[d]);
                    end else begin
                        mq[d*2 + int'(msel[d])].push_back(id[d]);
                        msel[d] = ~msel[d];
                    end
                end
            end
        end
        @(negedge clock);
        idle_all();
    endtask

`ifdef STREAM_SPLIT2_COUNT_EN
    task automatic test_count_wrap();
        do_reset();
        iv[0] = 1'b1; id[0] = 4'h5;
        repeat (65535) @(posedge clock);
        #1;
        iv[0] = 1'b0;
        tick();
        n_tests++; if (c0[0] !== 16'hFFFF || c1[0] !== 16'hFFFF) begin
            n_fail++; $display("FAIL cnt_preload: got c0=%0d c1=%0d want 65535 65535", c0[0], c1[0]); end
        r1[0] = 1'b0;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        n_tests++; if (c0[0] !== 16'h0000) begin n_fail++; $display("FAIL cnt_wrap_c0: got %0d want 0", c0[0]); end
        n_tests++; if (c1[0] !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_wrap_c1: got %0d want 65535", c1[0]); end
        r1[0] = 1'b1;
    endtask
`endif

    initial begin
        idle_all();
        test_reset();
        test_broadcast_b2b();
        test_broadcast_stall();
        test_rr_alternate();
        test_rr_stall();
        test_reset_mid();
        test_random();
`ifdef STREAM_SPLIT2_COUNT_EN
        test_count_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
